// File: rtl/hwreg_irq_ctrl_if.sv
// Hardware-register request bus between the memory address interpreter
// (master) and a register responder (slave). A request strobe is held
// until the responder returns a one-cycle ack.
interface hwreg_irq_ctrl_if;
    logic [31:0] hw_addr;
    logic [31:0] hw_data_i;
    logic        hw_ren;
    logic        hw_wen;
    logic [31:0] hw_data_o;
    logic        hw_ack;

    modport master (
        output hw_addr,
        output hw_data_i,
        output hw_ren,
        output hw_wen,
        input  hw_data_o,
        input  hw_ack
    );

    modport slave (
        input  hw_addr,
        input  hw_data_i,
        input  hw_ren,
        input  hw_wen,
        output hw_data_o,
        output hw_ack
    );
endinterface

// File: rtl/hwreg_irq_ctrl.sv
// Interrupt controller (I_STAT / I_MASK with KUSEG/KSEG0/KSEG1 mirrors) and
// the MEM_CTRL_3 cache-control register, answering requests on the hw_* bus.
// Every request is captured in IDLE, committed ACK_DELAY edges later and
// completed with a registered one-cycle ack. Peripheral interrupt lines are
// edge-detected into I_STAT and the masked OR drives a registered cpu_irq.
// ACK_DELAY must lie in 1..15 (the delay counter is 4 bits wide).
module hwreg_irq_ctrl #(
    parameter int ACK_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    hwreg_irq_ctrl_if.slave  hw,
    input  logic [10:0]      irq_src,
    output logic             cpu_irq,
    output logic [10:0]      i_stat_o,
    output logic [10:0]      i_mask_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Value of the delay counter on the commit edge.
    localparam logic [3:0] CNT_LAST = 4'(ACK_DELAY - 1);

    localparam logic [28:0] I_STAT_OFS = 29'h1F80_1070;
    localparam logic [28:0] I_MASK_OFS = 29'h1F80_1074;
    localparam logic [31:0] MC3_ADDR   = 32'hFFFF_0130;

    // Request bookkeeping
    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        is_read_reg;
    logic        ack_reg;
    logic [31:0] rdata_reg;

    // Architectural registers
    logic [10:0] i_stat_reg;
    logic [10:0] i_stat_next;
    logic [10:0] i_mask_reg;
    logic [31:0] mc3_reg;
    logic [10:0] irq_q_reg;
    logic        cpu_irq_reg;

    // Decode of the captured request
    logic        seg_ok;
    logic        sel_stat;
    logic        sel_mask;
    logic        sel_mc3;
    logic        commit;
    logic        wr_stat;
    logic        wr_mask;
    logic        wr_mc3;
    logic [31:0] rd_value;
    logic [10:0] rise;
    logic        strobe;

    assign strobe = hw.hw_ren | hw.hw_wen;

    // Only KUSEG (000), KSEG0 (100) and KSEG1 (101) mirror the I/O page;
    // MEM_CTRL_3 lives in KSEG2 and is matched on the full address.
    assign seg_ok   = (addr_reg[31:29] == 3'b000) ||
                      (addr_reg[31:29] == 3'b100) ||
                      (addr_reg[31:29] == 3'b101);
    assign sel_stat = seg_ok && (addr_reg[28:0] == I_STAT_OFS);
    assign sel_mask = seg_ok && (addr_reg[28:0] == I_MASK_OFS);
    assign sel_mc3  = (addr_reg == MC3_ADDR);

    // The commit edge is the last BUSY edge; decode uses captured values only.
    assign commit  = (state_reg == BUSY) && (cnt_reg == CNT_LAST);
    assign wr_stat = commit && !is_read_reg && sel_stat;
    assign wr_mask = commit && !is_read_reg && sel_mask;
    assign wr_mc3  = commit && !is_read_reg && sel_mc3;

    // Per-bit I_STAT update: acknowledge by AND-ing with the write data, then
    // OR in fresh rising edges so a set always wins over a same-edge clear.
    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_irq_bit
            assign rise[gi]        = irq_src[gi] & ~irq_q_reg[gi];
            assign i_stat_next[gi] = (wr_stat ? (i_stat_reg[gi] & wdata_reg[gi])
                                              : i_stat_reg[gi]) | rise[gi];
        end
    endgenerate

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_value = 32'd0;
        if (sel_stat) begin
            rd_value = {21'd0, i_stat_reg};
        end else if (sel_mask) begin
            rd_value = {21'd0, i_mask_reg};
        end else if (sel_mc3) begin
            rd_value = mc3_reg;
        end
    end

    // Request FSM: capture, count to the commit edge, pulse ack, wait for release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            addr_reg    <= 32'd0;
            wdata_reg   <= 32'd0;
            is_read_reg <= 1'b0;
            ack_reg     <= 1'b0;
            rdata_reg   <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    if (strobe) begin
                        addr_reg    <= hw.hw_addr;
                        wdata_reg   <= hw.hw_data_i;
                        // A read wins when both strobes are high.
                        is_read_reg <= hw.hw_ren;
                        cnt_reg     <= 4'd0;
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == CNT_LAST) begin
                        if (is_read_reg) begin
                            rdata_reg <= rd_value;
                        end
                        ack_reg   <= 1'b1;
                        state_reg <= ACK;
                    end
                end
                ACK: begin
                    ack_reg   <= 1'b0;
                    state_reg <= strobe ? HOLD : IDLE;
                end
                HOLD: begin
                    // A strobe still held from the finished request is not re-run.
                    ack_reg <= 1'b0;
                    if (!strobe) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    ack_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Plain read/write registers, written only on a write commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_mask_reg <= 11'd0;
            mc3_reg    <= 32'd0;
        end else begin
            if (wr_mask) begin
                i_mask_reg <= wdata_reg[10:0];
            end
            if (wr_mc3) begin
                mc3_reg <= wdata_reg;
            end
        end
    end

    // Interrupt capture: edge-detect sources, update I_STAT, register cpu_irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q_reg   <= 11'd0;
            i_stat_reg  <= 11'd0;
            cpu_irq_reg <= 1'b0;
        end else begin
            irq_q_reg   <= irq_src;
            i_stat_reg  <= i_stat_next;
            cpu_irq_reg <= |(i_stat_reg & i_mask_reg);
        end
    end

    assign hw.hw_ack    = ack_reg;
    assign hw.hw_data_o = rdata_reg;
    assign cpu_irq      = cpu_irq_reg;
    assign i_stat_o     = i_stat_reg;
    assign i_mask_o     = i_mask_reg;

endmodule

// File: tb/tb_hwreg_irq_ctrl.sv
// Scoreboard bench for hwreg_irq_ctrl: request tasks push the expected
// hw_data_o for each request; a monitor pops and compares on every ack.
module tb_hwreg_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [10:0] irq_src;
    logic        cpu_irq;
    logic [10:0] i_stat_o;
    logic [10:0] i_mask_o;
    logic        cpu_irq2;
    logic [10:0] i_stat2;
    logic [10:0] i_mask2;

    hwreg_irq_ctrl_if bus ();
    hwreg_irq_ctrl_if bus2 ();

    hwreg_irq_ctrl #(.ACK_DELAY(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .hw       (bus),
        .irq_src  (irq_src),
        .cpu_irq  (cpu_irq),
        .i_stat_o (i_stat_o),
        .i_mask_o (i_mask_o)
    );

    hwreg_irq_ctrl #(.ACK_DELAY(4)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .hw       (bus2),
        .irq_src  (irq_src),
        .cpu_irq  (cpu_irq2),
        .i_stat_o (i_stat2),
        .i_mask_o (i_mask2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          tests;
    int          fails;
    int          ack_count;
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: every ack pops one expectation and checks hw_data_o.
    initial begin
        logic prev_ack;
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ack = 1'b0;
            end else begin
                if (bus.hw_ack) begin
                    ack_count++;
                    check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_ack: got ack, required none");
                    end else begin
                        e = sb_q.pop_front();
                        check(e.name, bus.hw_data_o, e.exp);
                    end
                end
                prev_ack = bus.hw_ack;
            end
        end
    end

    // One request on the ACK_DELAY=1 instance; expected ack latency is 2 edges.
    task automatic do_req(input bit rd, input logic [31:0] a, input logic [31:0] d,
                          input string name, input logic [31:0] exp_rd);
        int n;
        bit got;
        exp_t e;
        @(posedge clk);
        #1;
        bus.hw_addr   = a;
        bus.hw_data_i = d;
        bus.hw_ren    = rd;
        bus.hw_wen    = !rd;
        if (rd) last_rd = exp_rd;
        e.exp  = last_rd;
        e.name = name;
        sb_q.push_back(e);
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            // Scramble the bus after capture: the DUT must use captured values.
            if (n == 1) begin
                bus.hw_addr   = ~a;
                bus.hw_data_i = ~d;
            end
            if (bus.hw_ack) got = 1;
        end
        bus.hw_ren = 1'b0;
        bus.hw_wen = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: no ack within 40 cycles, required ack", name);
            void'(sb_q.pop_back());
        end else begin
            check({name, "_latency"}, 32'(n), 32'd2);
        end
        @(posedge clk);
        #1;
    endtask

    // One request on the ACK_DELAY=4 instance; expected ack latency is 5 edges.
    task automatic do_req2(input bit rd, input logic [31:0] a, input logic [31:0] d,
                           input string name, input logic [31:0] exp_rd);
        int n;
        bit got;
        @(posedge clk);
        #1;
        bus2.hw_addr   = a;
        bus2.hw_data_i = d;
        bus2.hw_ren    = rd;
        bus2.hw_wen    = !rd;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus2.hw_ack) got = 1;
        end
        bus2.hw_ren = 1'b0;
        bus2.hw_wen = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: no ack within 40 cycles, required ack", name);
        end else begin
            check({name, "_latency"}, 32'(n), 32'd5);
            if (rd) check({name, "_data"}, bus2.hw_data_o, exp_rd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int n;
        tests     = 0;
        fails     = 0;
        ack_count = 0;
        last_rd   = 32'd0;
        rst       = 1'b1;
        irq_src   = 11'd0;
        bus.hw_addr    = 32'd0;
        bus.hw_data_i  = 32'd0;
        bus.hw_ren     = 1'b0;
        bus.hw_wen     = 1'b0;
        bus2.hw_addr   = 32'd0;
        bus2.hw_data_i = 32'd0;
        bus2.hw_ren    = 1'b0;
        bus2.hw_wen    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset defaults
        check("rst_ack", {31'd0, bus.hw_ack}, 32'd0);
        check("rst_data_o", bus.hw_data_o, 32'd0);
        check("rst_cpu_irq", {31'd0, cpu_irq}, 32'd0);
        check("rst_i_stat", {21'd0, i_stat_o}, 32'd0);
        do_req(1, 32'hBF80_1074, 32'd0, "rd_mask_default", 32'd0);

        // Mask bit 0, raise VBLANK
        do_req(0, 32'h1F80_1074, 32'h0000_0001, "wr_mask_1", 32'd0);
        @(posedge clk);
        #1;
        irq_src[0] = 1'b1;
        @(posedge clk);
        #1;
        check("irq0_stat", {21'd0, i_stat_o}, 32'h001);
        check("irq0_cpu_lag", {31'd0, cpu_irq}, 32'd0);
        irq_src[0] = 1'b0;
        @(posedge clk);
        #1;
        check("irq0_cpu", {31'd0, cpu_irq}, 32'd1);
        do_req(0, 32'h1F80_1070, 32'hFFFF_FFFE, "wr_stat_ack0", 32'd0);
        check("ack0_stat", {21'd0, i_stat_o}, 32'h000);
        check("ack0_cpu", {31'd0, cpu_irq}, 32'd0);
        do_req(1, 32'h1F80_1070, 32'd0, "rd_stat_0", 32'd0);

        // Set beats acknowledge on the same edge
        @(posedge clk);
        #1;
        irq_src[2] = 1'b1;
        @(posedge clk);
        #1;
        irq_src[2] = 1'b0;
        check("irq2_stat", {21'd0, i_stat_o}, 32'h004);
        fork
            do_req(0, 32'h1F80_1070, 32'd0, "wr_stat_race", 32'd0);
            begin
                @(posedge clk);
                @(posedge clk);
                #2;
                irq_src[2] = 1'b1;
            end
        join
        check("set_beats_ack", {21'd0, i_stat_o}, 32'h004);
        irq_src[2] = 1'b0;
        do_req(0, 32'h1F80_1070, 32'd0, "wr_stat_clear", 32'd0);
        check("stat_cleared", {21'd0, i_stat_o}, 32'h000);

        // Mirrors, upper I_MASK bits, MEM_CTRL_3
        do_req(0, 32'h9F80_1074, 32'h0000_07FF, "wr_mask_kseg0", 32'd0);
        check("mask_7ff", {21'd0, i_mask_o}, 32'h7FF);
        do_req(1, 32'h1F80_1074, 32'd0, "rd_mask_kuseg", 32'h0000_07FF);
        do_req(1, 32'hBF80_1074, 32'd0, "rd_mask_kseg1", 32'h0000_07FF);
        do_req(0, 32'h1F80_1074, 32'hFFFF_F801, "wr_mask_upper", 32'd0);
        do_req(1, 32'h1F80_1074, 32'd0, "rd_mask_upper0", 32'h0000_0001);
        do_req(0, 32'h1F80_1074, 32'h0000_07FF, "wr_mask_7ff", 32'd0);
        do_req(0, 32'hFFFF_0130, 32'h0001_E988, "wr_mc3", 32'd0);
        do_req(1, 32'hFFFF_0130, 32'd0, "rd_mc3", 32'h0001_E988);

        // Unmapped addresses
        do_req(0, 32'h1F80_1800, 32'hDEAD_BEEF, "wr_unmapped", 32'd0);
        do_req(1, 32'h1F80_1800, 32'd0, "rd_unmapped", 32'd0);
        do_req(1, 32'h3F80_1074, 32'd0, "rd_bad_segment", 32'd0);
        do_req(1, 32'h1FFF_0130, 32'd0, "rd_mc3_alias", 32'd0);
        check("unmapped_mask_kept", {21'd0, i_mask_o}, 32'h7FF);
        do_req(1, 32'hFFFF_0130, 32'd0, "rd_mc3_kept", 32'h0001_E988);

        // Read held high past the ack: exactly one ack
        a0 = ack_count;
        @(posedge clk);
        #1;
        bus.hw_addr = 32'h1F80_1074;
        bus.hw_ren  = 1'b1;
        last_rd = 32'h0000_07FF;
        sb_q.push_back('{exp: 32'h0000_07FF, name: "rd_hold"});
        n = 0;
        while (!bus.hw_ack && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hold_ack_seen", {31'd0, bus.hw_ack}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bus.hw_ren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_one_ack", 32'(ack_count - a0), 32'd1);
        do_req(1, 32'hFFFF_0130, 32'd0, "rd_after_hold", 32'h0001_E988);

        // ACK_DELAY=4 instance
        do_req2(1, 32'h1F80_1800, 32'd0, "d4_rd_unmapped", 32'd0);
        do_req2(0, 32'hFFFF_0130, 32'h1234_5678, "d4_wr_mc3", 32'd0);
        do_req2(1, 32'hFFFF_0130, 32'd0, "d4_rd_mc3", 32'h1234_5678);

        // Reset while BUSY: write lost, no ack; high source sets after release
        a0 = ack_count;
        @(posedge clk);
        #1;
        bus.hw_addr   = 32'hFFFF_0130;
        bus.hw_data_i = 32'hAAAA_5555;
        bus.hw_wen    = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.hw_wen = 1'b0;
        irq_src[5] = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy_no_ack", {31'd0, bus.hw_ack}, 32'd0);
        rst = 1'b0;
        check("rst_busy_stat", {21'd0, i_stat_o}, 32'h000);
        @(posedge clk);
        #1;
        check("rst_release_irq5", {21'd0, i_stat_o}, 32'h020);
        check("rst_busy_ack_count", 32'(ack_count - a0), 32'd0);
        check("rst_busy_mask", {21'd0, i_mask_o}, 32'h000);
        irq_src[5] = 1'b0;
        last_rd = 32'd0;
        do_req(1, 32'hFFFF_0130, 32'd0, "rd_mc3_after_rst", 32'd0);
        check("rst_cpu_irq_masked", {31'd0, cpu_irq}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hwreg_irq_ctrl.md
# hwreg_irq_ctrl

Hardware-register responder on the `hw_*` bus driven by the memory address interpreter. Implements the interrupt controller (I_STAT at 0x1F801070, I_MASK at 0x1F801074, KUSEG/KSEG0/KSEG1 mirrors) and the cache-control register MEM_CTRL_3 at 0xFFFF0130. It completes every `hw_ren`/`hw_wen` request with a one-cycle `hw_ack`, latches peripheral interrupt edges and drives the CPU interrupt line.

## Interface
- `ACK_DELAY`, default 1: cycles from request capture to commit/ack. Legal range is 1..15.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `hw_addr` in 32: request address, byte address.
- `hw_data_i` in 32: write data; full-word writes only.
- `hw_ren` in 1: read request, held high until ack.
- `hw_wen` in 1: write request, held high until ack.
- `hw_data_o` out 32: read data; valid from the ack cycle until the next read commits.
- `hw_ack` out 1: completion, a one-cycle pulse.
- `irq_src` in 11: peripheral interrupt lines (VBLANK=bit0 … bit10), level inputs, rising-edge sensitive.
- `cpu_irq` out 1: registered `|(I_STAT & I_MASK)`.
- `i_stat_o` out 11: current I_STAT, for debug.
- `i_mask_o` out 11: current I_MASK, for debug.

## Operation
- **Address decode.** `addr[31:29]` must be one of {000, 100, 101}.
  - `addr[28:0]` = 0x1F801070 selects I_STAT; 0x1F801074 selects I_MASK.
  - `hw_addr` = 0xFFFF0130 exactly selects MEM_CTRL_3.
  - Every other address is unmapped: reads return 0, writes are discarded, and the request is still acked.
- **Registers.**
  - I_STAT: 11 bits. Read returns `{21'd0, I_STAT}`. A write acknowledges interrupts: `I_STAT &= hw_data_i[10:0]`.
  - I_MASK: 11 bits, plain read/write. Upper bits are read as 0.
  - MEM_CTRL_3: 32 bits, plain read/write.
- **Interrupt capture.**
  - `irq_q` registers `irq_src`; its reset value is 0.
  - Rising-edge vector: `rise = irq_src & ~irq_q`.
  - Every cycle: `I_STAT_next = (write_commit_to_I_STAT ? I_STAT & hw_data_i[10:0] : I_STAT) | rise`. A set always beats an acknowledge on the same edge.
  - A source that is high when reset releases sets its bit on the first edge after reset.
- **FSM states:** IDLE, BUSY, ACK, HOLD.
  - IDLE: when `hw_ren | hw_wen`, capture addr, data and op (`hw_ren` wins if both are high → read). Load `cnt = 0` and go to BUSY.
  - BUSY: `cnt++` each edge. On the edge where `cnt == ACK_DELAY-1`, commit the write or load `hw_data_o` with the read value, then go to ACK.
  - ACK: `hw_ack = 1`. Next edge: go to IDLE if both strobes are low, else go to HOLD.
  - HOLD: `hw_ack = 0`; wait until both strobes are low, then go to IDLE.
- Decode, write data and op all use the values captured in IDLE. Changes on `hw_addr`/`hw_data_i` after capture are ignored.
- `hw_data_o` is not updated by writes or unmapped writes. It is updated only by a read commit (unmapped read commits 0).

## Timing
- **Reset values:** `hw_ack` = 0, `hw_data_o` = 0, `cpu_irq` = 0, I_STAT = 0, I_MASK = 0, MEM_CTRL_3 = 0, `irq_q` = 0, state = IDLE, `cnt` = 0.
- **Request-to-ack latency.** Strobe sampled high at edge E0 → commit at edge E(ACK_DELAY) → `hw_ack` high for the cycle after that edge.
  - With ACK_DELAY=1: ack is visible 2 cycles after the strobe first appears.
- `hw_ack` is registered and lasts exactly one cycle per request.
- Back-to-back requests: a new strobe is accepted only in IDLE. The minimum spacing is ACK_DELAY + 2 edges per transaction.
- `cpu_irq` lags an I_STAT/I_MASK change by one cycle. An `irq_src` rising edge therefore reaches `cpu_irq` 2 edges after it is sampled (first the I_STAT set, then the `cpu_irq` register).
- Reset mid-transaction: all state is cleared on the reset edge; no ack is issued and the pending write is lost.
- A strobe that is still high in HOLD is not re-executed.

## Test plan
- **Reset defaults:** after reset, read 0xBF801074 → `hw_ack` one cycle, `hw_data_o` = 0x00000000; `cpu_irq` = 0.
- **Mask/interrupt:** write 0x1F801074 = 0x00000001, then pulse `irq_src[0]` → I_STAT = 0x001 and `cpu_irq` = 1 two edges after the rise. Writing I_STAT = 0xFFFFFFFE clears it → `cpu_irq` = 0 one cycle later.
- **Set-beats-ack:** I_STAT = 0x004; commit a write of 0x0 on the same edge that `irq_src[2]` rises again → I_STAT = 0x004.
- **Mirrors/MEM_CTRL_3:** write 0x9F801074 = 0x7FF, read 0x1F801074 → 0x000007FF. Write 0xFFFF0130 = 0x0001E988, read it back → 0x0001E988.
- **Unmapped:** write then read 0x1F801800 → both acked, read returns 0, no register changes. With ACK_DELAY=4 the ack appears 5 cycles after the strobe.
- **Protocol:** hold `hw_ren` high 3 cycles past ack → only one ack, and the FSM sits in HOLD until the strobe drops. Assert `rst` in BUSY during a write → no ack, target register unchanged (0).
